// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch unit. Holds the fetch program counter, presents it to a
// combinational instruction memory, and buffers fetched words in a 2-entry
// prefetch queue that the decoder drains with a valid/ready handshake. A
// single redirect port flushes the queue and restarts fetch elsewhere.
//
// Optional feature macro: FETCH_HALT_EN
//   defined   : a fetched opcode of 0 stops fetch (HALTED) until redirect/reset
//   undefined : opcode 0 is ordinary, halted is tied 0
//
// Ports
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   Read_Address   out  instruction memory address (= fetch_pc, combinational)
//   instruction    in   memory data for Read_Address
//   inst_out       out  instruction at queue head (registered)
//   pc_out         out  address inst_out was fetched from (registered)
//   inst_valid     out  queue non-empty
//   inst_ready     in   decoder accepts the head this cycle
//   redirect       in   flush queue, restart fetch at redirect_addr
//   redirect_addr  in   new fetch address, taken modulo MEM_DEPTH
//   halted         out  fetch stopped on halt opcode (FETCH_HALT_EN only)
//
// FSM states (FETCH_HALT_EN build)
//   state  | meaning
//   RUN    | fetching one word per cycle whenever the queue has room
//   HALTED | halt opcode enqueued; fetch_pc frozen, queue still drains
// ----------------------------------------------------------------------------
module instr_fetch #(
  parameter int ADDR_W    = 8,
  parameter int INSTR_W   = 8,
  parameter int MEM_DEPTH = 32,
  parameter int RESET_PC  = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  Read_Address,
  input  logic [INSTR_W-1:0] instruction,
  output logic [INSTR_W-1:0] inst_out,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               inst_valid,
  input  logic               inst_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic               halted
);

  // MEM_DEPTH is a power of two, so modulo reduces to a mask.
  localparam logic [ADDR_W-1:0] PC_MASK  = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [ADDR_W-1:0] PC_RESET = ADDR_W'(RESET_PC);

  logic [ADDR_W-1:0]  fetch_pc;
  logic [ADDR_W-1:0]  head_pc;
  logic [ADDR_W-1:0]  tail_pc;
  logic [INSTR_W-1:0] head_instr;
  logic [INSTR_W-1:0] tail_instr;
  logic [1:0]         count;

  logic               running;
  logic               pop;
  logic               push;
  logic [ADDR_W-1:0]  pc_inc;
  logic [ADDR_W-1:0]  redirect_pc;

`ifdef FETCH_HALT_EN
  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t state;

  assign running = (state == RUN);
  assign halted  = (state == HALTED);
`else
  assign running = 1'b1;
  assign halted  = 1'b0;
`endif

  assign Read_Address = fetch_pc;
  assign inst_out     = head_instr;
  assign pc_out       = head_pc;
  assign inst_valid   = (count != 2'd0);

  assign pc_inc      = (fetch_pc + 1'b1) & PC_MASK;
  assign redirect_pc = redirect_addr & PC_MASK;

  // A handshake during redirect is still a pop; the flush discards the rest.
  assign pop  = inst_valid && inst_ready;
  assign push = running && !redirect && ((count != 2'd2) || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc   <= PC_RESET;
      count      <= 2'd0;
      head_pc    <= '0;
      head_instr <= '0;
      tail_pc    <= '0;
      tail_instr <= '0;
`ifdef FETCH_HALT_EN
      state      <= RUN;
`endif
    end else if (redirect) begin
      count    <= 2'd0;
      fetch_pc <= redirect_pc;
`ifdef FETCH_HALT_EN
      state    <= RUN;
`endif
    end else begin
      if (push) begin
        fetch_pc <= pc_inc;
`ifdef FETCH_HALT_EN
        // Halt word is enqueued normally; fetch_pc still advances past it.
        if (instruction == '0) begin
          state <= HALTED;
        end
`endif
      end

      case ({push, pop})
        2'b10: begin
          // Push only: fill the first free slot.
          if (count == 2'd0) begin
            head_pc    <= fetch_pc;
            head_instr <= instruction;
          end else begin
            tail_pc    <= fetch_pc;
            tail_instr <= instruction;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          // Pop only: tail moves up (harmless if tail was empty).
          head_pc    <= tail_pc;
          head_instr <= tail_instr;
          count      <= count - 2'd1;
        end
        2'b11: begin
          // Push and pop: count unchanged, order preserved.
          if (count == 2'd1) begin
            head_pc    <= fetch_pc;
            head_instr <= instruction;
          end else begin
            head_pc    <= tail_pc;
            head_instr <= tail_instr;
            tail_pc    <= fetch_pc;
            tail_instr <= instruction;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic       clk;
  logic       rst_n;
  logic [7:0] Read_Address;
  logic [7:0] instruction;
  logic [7:0] inst_out;
  logic [7:0] pc_out;
  logic       inst_valid;
  logic       inst_ready;
  logic       redirect;
  logic [7:0] redirect_addr;
  logic       halted;

  logic [7:0] mem [32];

  int checks;
  int errors;

  instr_fetch #(
    .ADDR_W   (8),
    .INSTR_W  (8),
    .MEM_DEPTH(32),
    .RESET_PC (0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .Read_Address (Read_Address),
    .instruction  (instruction),
    .inst_out     (inst_out),
    .pc_out       (pc_out),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .redirect     (redirect),
    .redirect_addr(redirect_addr),
    .halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign instruction = mem[Read_Address[4:0]];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic load_image();
    for (int i = 0; i < 32; i++) mem[i] = 8'hA0 + 8'(i);
    mem[0]  = 8'h45;
    mem[1]  = 8'h84;
    mem[2]  = 8'h58;
    mem[21] = 8'h45;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    inst_ready    = 1'b1;
    redirect      = 1'b0;
    redirect_addr = 8'd0;
    load_image();

    // Reset state
    #3;
    chk("rst_valid", inst_valid, 0);
    chk("rst_inst", inst_out, 0);
    chk("rst_pc", pc_out, 0);
    chk("rst_ra", Read_Address, 0);
    chk("rst_halted", halted, 0);
    step();
    rst_n = 1'b1;
    chk("rel_ra", Read_Address, 0);
    chk("rel_valid", inst_valid, 0);

    // Sequential fetch, ready held high
    step();
    chk("seq0_valid", inst_valid, 1);
    chk("seq0_inst", inst_out, 8'h45);
    chk("seq0_pc", pc_out, 0);
    step();
    chk("seq1_inst", inst_out, 8'h84);
    chk("seq1_pc", pc_out, 1);
    step();
    chk("seq2_inst", inst_out, 8'h58);
    chk("seq2_pc", pc_out, 2);

    // Backpressure from reset: queue fills, fetch stalls at 2
    rst_n      = 1'b0;
    inst_ready = 1'b0;
    #1;
    rst_n = 1'b1;
    chk("bp_ra0", Read_Address, 0);
    repeat (5) step();
    chk("bp_valid", inst_valid, 1);
    chk("bp_inst", inst_out, 8'h45);
    chk("bp_pc", pc_out, 0);
    chk("bp_ra", Read_Address, 2);
    inst_ready = 1'b1;
    step();
    chk("bp_rel0_inst", inst_out, 8'h84);
    chk("bp_rel0_pc", pc_out, 1);
    step();
    chk("bp_rel1_inst", inst_out, 8'h58);
    chk("bp_rel1_pc", pc_out, 2);
    step();
    chk("bp_rel2_inst", inst_out, 8'hA3);
    chk("bp_rel2_pc", pc_out, 3);

    // Redirect while full
    inst_ready = 1'b0;
    step();
    step();
    chk("full_ra", Read_Address, 5);
    chk("full_pc", pc_out, 3);
    redirect      = 1'b1;
    redirect_addr = 8'd21;
    step();
    redirect = 1'b0;
    chk("rd_valid0", inst_valid, 0);
    chk("rd_ra", Read_Address, 21);
    step();
    chk("rd_valid1", inst_valid, 1);
    chk("rd_inst", inst_out, 8'h45);
    chk("rd_pc", pc_out, 21);
    step();
    step();
    chk("rd_hold_inst", inst_out, 8'h45);
    chk("rd_hold_pc", pc_out, 21);
    chk("rd_hold_ra", Read_Address, 23);
    inst_ready = 1'b1;
    step();
    chk("rd_next_inst", inst_out, 8'hB6);
    chk("rd_next_pc", pc_out, 22);

    // Wrap-around: data tracks address (top bit set so no word reads as 0)
    for (int i = 0; i < 32; i++) mem[i] = 8'h80 | 8'(i);
    redirect      = 1'b1;
    redirect_addr = 8'd30;
    step();
    redirect = 1'b0;
    chk("wr_valid0", inst_valid, 0);
    chk("wr_ra", Read_Address, 30);
    step();
    chk("wr30_pc", pc_out, 30);
    chk("wr30_inst", inst_out, 8'h9E);
    step();
    chk("wr31_pc", pc_out, 31);
    chk("wr31_inst", inst_out, 8'h9F);
    step();
    chk("wr0_pc", pc_out, 0);
    chk("wr0_inst", inst_out, 8'h80);
    step();
    chk("wr1_pc", pc_out, 1);
    chk("wr1_valid", inst_valid, 1);

    load_image();

`ifdef FETCH_HALT_EN
    // Halt opcode at 20
    mem[20]       = 8'h00;
    redirect      = 1'b1;
    redirect_addr = 8'd20;
    step();
    redirect = 1'b0;
    chk("h_valid0", inst_valid, 0);
    step();
    chk("h_valid1", inst_valid, 1);
    chk("h_inst", inst_out, 8'h00);
    chk("h_pc", pc_out, 20);
    chk("h_halted", halted, 1);
    chk("h_ra", Read_Address, 21);
    step();
    chk("h_drain_valid", inst_valid, 0);
    chk("h_drain_ra", Read_Address, 21);
    step();
    chk("h_stay_valid", inst_valid, 0);
    chk("h_stay_halted", halted, 1);
    redirect      = 1'b1;
    redirect_addr = 8'd0;
    step();
    redirect = 1'b0;
    chk("h_clr_halted", halted, 0);
    chk("h_clr_ra", Read_Address, 0);
    step();
    chk("h_re_inst", inst_out, 8'h45);
    chk("h_re_pc", pc_out, 0);
`else
    chk("nohalt_tied0", halted, 0);
`endif

    // Async reset mid-stream with queue full
    inst_ready    = 1'b0;
    redirect      = 1'b1;
    redirect_addr = 8'd1;
    step();
    redirect = 1'b0;
    step();
    step();
    step();
    chk("ar_full_inst", inst_out, 8'h84);
    chk("ar_full_pc", pc_out, 1);
    chk("ar_full_ra", Read_Address, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", inst_valid, 0);
    chk("ar_inst", inst_out, 0);
    chk("ar_pc", pc_out, 0);
    chk("ar_ra", Read_Address, 0);
    chk("ar_halted", halted, 0);
    #1;
    rst_n      = 1'b1;
    inst_ready = 1'b1;
    step();
    chk("ar_re_valid", inst_valid, 1);
    chk("ar_re_inst", inst_out, 8'h45);
    chk("ar_re_pc", pc_out, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
